// File: rtl/keypad_scan_if.sv
// rtl/keypad_scan_if.sv - keypad matrix lines and decoded key outputs
// master: scanner side; slave: keypad/consumer side.
interface keypad_scan_if;
  logic [3:0] row;
  logic [3:0] col;
  logic [3:0] key_val;
  logic       key_valid;
  logic       key_down;

  modport master (
    input  row,
    output col, key_val, key_valid, key_down
  );

  modport slave (
    output row,
    input  col, key_val, key_valid, key_down
  );
endinterface

// File: rtl/keypad_scan.sv
// rtl/keypad_scan.sv - 4x4 keypad column scanner with whole-scan debounce
// Drives one column low per SCAN_CYCLES, classifies each scan and accepts stable keys.
module keypad_scan #(
  parameter int SCAN_CYCLES    = 100000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic          clk,
  input  logic          reset,
  keypad_scan_if.master kp
);

  localparam int CNT_W = $clog2(SCAN_CYCLES);
  localparam int DB_W  = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_CYCLES - 1);
  localparam logic [DB_W-1:0]  DB_FULL  = DB_W'(DEBOUNCE_SCANS);

  typedef enum logic [1:0] {RES_NONE, RES_KEY, RES_MULTI} res_e;

  logic [3:0]       row_meta_q, row_sync_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       idx_q, idx_d;
  logic [3:0]       col_q, col_d;
  logic [1:0]       acc_cnt_q, acc_cnt_d;
  logic [3:0]       acc_code_q, acc_code_d;
  res_e             prev_cls_q, prev_cls_d;
  logic [3:0]       prev_code_q, prev_code_d;
  logic [DB_W-1:0]  stable_q, stable_d;
  logic             eval_q, eval_d;
  logic [3:0]       key_val_q, key_val_d;
  logic             key_valid_q, key_valid_d;
  logic             key_down_q, key_down_d;

  logic             sample;
  logic [3:0]       row_low;
  logic [2:0]       n_low;
  logic [1:0]       row_sel;
  logic [2:0]       total;
  logic [1:0]       tot_sat;
  logic [3:0]       col_code;
  res_e             scan_cls;
  logic [3:0]       scan_code;

  function automatic logic [3:0] key_code(input logic [1:0] c, input logic [1:0] r);
    case ({r, c})
      4'h0: key_code = 4'h1;  4'h1: key_code = 4'h2;  4'h2: key_code = 4'h3;  4'h3: key_code = 4'hA;
      4'h4: key_code = 4'h4;  4'h5: key_code = 4'h5;  4'h6: key_code = 4'h6;  4'h7: key_code = 4'hB;
      4'h8: key_code = 4'h7;  4'h9: key_code = 4'h8;  4'hA: key_code = 4'h9;  4'hB: key_code = 4'hC;
      4'hC: key_code = 4'h0;  4'hD: key_code = 4'hF;  4'hE: key_code = 4'hE;  default: key_code = 4'hD;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      row_meta_q  <= 4'hF;
      row_sync_q  <= 4'hF;
      cnt_q       <= '0;
      idx_q       <= 2'd0;
      col_q       <= 4'b1110;
      acc_cnt_q   <= 2'd0;
      acc_code_q  <= 4'h0;
      prev_cls_q  <= RES_NONE;
      prev_code_q <= 4'h0;
      stable_q    <= '0;
      eval_q      <= 1'b0;
      key_val_q   <= 4'h0;
      key_valid_q <= 1'b0;
      key_down_q  <= 1'b0;
    end else begin
      row_meta_q  <= kp.row;
      row_sync_q  <= row_meta_q;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      col_q       <= col_d;
      acc_cnt_q   <= acc_cnt_d;
      acc_code_q  <= acc_code_d;
      prev_cls_q  <= prev_cls_d;
      prev_code_q <= prev_code_d;
      stable_q    <= stable_d;
      eval_q      <= eval_d;
      key_val_q   <= key_val_d;
      key_valid_q <= key_valid_d;
      key_down_q  <= key_down_d;
    end
  end

  always_comb begin
    cnt_d       = cnt_q + CNT_W'(1);
    idx_d       = idx_q;
    col_d       = col_q;
    acc_cnt_d   = acc_cnt_q;
    acc_code_d  = acc_code_q;
    prev_cls_d  = prev_cls_q;
    prev_code_d = prev_code_q;
    stable_d    = stable_q;
    eval_d      = 1'b0;
    key_val_d   = key_val_q;
    key_valid_d = 1'b0;
    key_down_d  = key_down_q;

    sample  = (cnt_q == CNT_LAST);
    row_low = ~row_sync_q;
    n_low   = 3'd0;
    row_sel = 2'd0;
    for (int r = 0; r < 4; r++) begin
      if (row_low[r]) begin
        n_low   = n_low + 3'd1;
        row_sel = 2'(r);
      end
    end

    // Low-row tally saturates at 2: only none/one/many matters for the scan class.
    total    = {1'b0, acc_cnt_q} + n_low;
    tot_sat  = (total > 3'd2) ? 2'd2 : total[1:0];
    col_code = (acc_cnt_q == 2'd0 && n_low == 3'd1) ? key_code(idx_q, row_sel) : acc_code_q;
    scan_cls = (tot_sat == 2'd0) ? RES_NONE : (tot_sat == 2'd1) ? RES_KEY : RES_MULTI;
    scan_code = (scan_cls == RES_KEY) ? col_code : 4'h0;

    if (sample) begin
      cnt_d = '0;
      idx_d = idx_q + 2'd1;
      col_d = ~(4'b0001 << idx_d);
      if (idx_q == 2'd3) begin
        acc_cnt_d  = 2'd0;
        acc_code_d = 4'h0;
        eval_d     = 1'b1;
        if (scan_cls == prev_cls_q && scan_code == prev_code_q) begin
          stable_d = (stable_q == DB_FULL) ? stable_q : stable_q + DB_W'(1);
        end else begin
          stable_d    = DB_W'(1);
          prev_cls_d  = scan_cls;
          prev_code_d = scan_code;
        end
      end else begin
        acc_cnt_d  = tot_sat;
        acc_code_d = col_code;
      end
    end

    // A held key never re-strobes; only a stable NONE re-arms the press path.
    if (eval_q && stable_q == DB_FULL) begin
      case (prev_cls_q)
        RES_KEY: begin
          if (!key_down_q) begin
            key_val_d   = prev_code_q;
            key_valid_d = 1'b1;
            key_down_d  = 1'b1;
          end
        end
        RES_NONE: key_down_d = 1'b0;
        default: ;
      endcase
    end
  end

  assign kp.col       = col_q;
  assign kp.key_val   = key_val_q;
  assign kp.key_valid = key_valid_q;
  assign kp.key_down  = key_down_q;

endmodule

// File: tb/tb_keypad_scan.sv
// tb/tb_keypad_scan.sv - directed and random keypad scenarios against a scan-level model
module tb_keypad_scan;
  localparam int SC = 8;
  localparam int DB = 3;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  keypad_scan_if kif ();

  keypad_scan #(.SCAN_CYCLES(SC), .DEBOUNCE_SCANS(DB)) dut (
    .clk   (clk),
    .reset (reset),
    .kp    (kif)
  );

  // keys bit index = col*4 + row; a pressed key pulls its row low while its column is low
  logic [15:0] keys = 16'h0;
  always_comb begin
    for (int r = 0; r < 4; r++) begin
      kif.row[r] = 1'b1;
      for (int c = 0; c < 4; c++)
        if (keys[c*4+r] && !kif.col[c]) kif.row[r] = 1'b0;
    end
  end

  int evals = 0;
  int fails = 0;
  int pulse_cnt = 0;
  logic [3:0] kmap [0:15];

  int prev_res;
  int stable;
  logic [3:0] cur_val, pend_val;
  logic cur_down, pend_down, pend_pulse;

  always @(negedge clk) if (kif.key_valid === 1'b1) pulse_cnt++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    evals++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // -1 = no key, -2 = several keys, otherwise the hex code
  function automatic int scan_result(input logic [15:0] m);
    if ($countones(m) == 0) return -1;
    if ($countones(m) > 1) return -2;
    for (int i = 0; i < 16; i++) if (m[i]) return int'(kmap[i]);
    return -1;
  endfunction

  task automatic model_reset();
    prev_res = -1;
    stable = 0;
    cur_val = 4'h0;
    cur_down = 1'b0;
    pend_val = 4'h0;
    pend_down = 1'b0;
    pend_pulse = 1'b0;
  endtask

  task automatic model_scan_end(input logic [15:0] m);
    int res;
    res = scan_result(m);
    if (res == prev_res) stable = (stable < DB) ? stable + 1 : DB;
    else begin
      stable = 1;
      prev_res = res;
    end
    pend_val = cur_val;
    pend_down = cur_down;
    pend_pulse = 1'b0;
    if (stable == DB) begin
      if (res >= 0 && !cur_down) begin
        pend_val = 4'(res);
        pend_down = 1'b1;
        pend_pulse = 1'b1;
      end else if (res == -1) begin
        pend_down = 1'b0;
      end
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk); #1;
    check("reset_col", kif.col, 4'b1110);
    check("reset_key_val", kif.key_val, 4'h0);
    check("reset_key_valid", kif.key_valid, 1'b0);
    check("reset_key_down", kif.key_down, 1'b0);
    reset = 1'b0;
    model_reset();
  endtask

  // Called #1 after a scan-start edge; returns #1 after the next one.
  task automatic do_scan(input logic [15:0] m);
    logic [3:0] ec;
    keys = m;
    for (int j = 0; j < 4*SC; j++) begin
      if (j == 1) begin
        cur_val = pend_val;
        cur_down = pend_down;
      end
      ec = ~(4'b0001 << (j / SC));
      check("col", kif.col, ec);
      check("key_valid", kif.key_valid, (j == 1) && pend_pulse);
      check("key_val", kif.key_val, cur_val);
      check("key_down", kif.key_down, cur_down);
      @(posedge clk); #1;
    end
    model_scan_end(m);
  endtask

  initial begin
    logic [15:0] m;
    int a, b, hold;
    kmap[0] = 4'h1;  kmap[1] = 4'h4;  kmap[2] = 4'h7;  kmap[3] = 4'h0;
    kmap[4] = 4'h2;  kmap[5] = 4'h5;  kmap[6] = 4'h8;  kmap[7] = 4'hF;
    kmap[8] = 4'h3;  kmap[9] = 4'h6;  kmap[10] = 4'h9; kmap[11] = 4'hE;
    kmap[12] = 4'hA; kmap[13] = 4'hB; kmap[14] = 4'hC; kmap[15] = 4'hD;
    #1;
    do_reset();
    do_scan(16'h0);
    repeat (20) @(posedge clk);
    #1;
    check("mid_col2_before_reset", kif.col, 4'b1011);
    do_reset();
    repeat (2) do_scan(16'h0);

    // single press (1,1) then long hold
    repeat (3) do_scan(16'h0020);
    do_scan(16'h0020);
    check("single_press_pulses", pulse_cnt, 1);
    check("single_press_val", kif.key_val, 4'h5);
    repeat (20) do_scan(16'h0020);
    check("hold_no_repulse", pulse_cnt, 1);

    // release, then press (3,3)
    repeat (4) do_scan(16'h0);
    check("release_down", kif.key_down, 1'b0);
    check("release_val_held", kif.key_val, 4'h5);
    repeat (4) do_scan(16'h8000);
    check("press_d_pulses", pulse_cnt, 2);
    check("press_d_val", kif.key_val, 4'hD);

    // bounce on (2,0)
    repeat (3) do_scan(16'h0);
    for (int i = 0; i < 10; i++) do_scan((i % 2 == 0) ? 16'h0100 : 16'h0);
    check("bounce_no_pulse", pulse_cnt, 2);
    check("bounce_down", kif.key_down, 1'b0);
    repeat (4) do_scan(16'h0100);
    check("bounce_settle_val", kif.key_val, 4'h3);

    // multi-key (0,0)+(2,2), then release (2,2)
    repeat (4) do_scan(16'h0);
    repeat (4) do_scan(16'h0401);
    check("multi_no_pulse", pulse_cnt, 3);
    check("multi_val_held", kif.key_val, 4'h3);
    repeat (4) do_scan(16'h0001);
    check("multi_then_single_val", kif.key_val, 4'h1);

    // reset mid-debounce on (1,3)
    repeat (4) do_scan(16'h0);
    repeat (2) do_scan(16'h0080);
    do_reset();
    repeat (2) do_scan(16'h0080);
    check("reset_debounce_no_pulse", pulse_cnt, 4);
    repeat (2) do_scan(16'h0080);
    check("reset_debounce_val", kif.key_val, 4'hF);
    check("reset_debounce_pulses", pulse_cnt, 5);

    // random key activity
    for (int it = 0; it < 30; it++) begin
      a = $urandom_range(0, 99);
      if (a < 45) m = 16'h0;
      else if (a < 85) m = 16'(1) << $urandom_range(0, 15);
      else begin
        a = $urandom_range(0, 15);
        b = (a + 1 + $urandom_range(0, 14)) % 16;
        m = (16'(1) << a) | (16'(1) << b);
      end
      hold = $urandom_range(1, 5);
      repeat (hold) do_scan(m);
    end
    repeat (4) do_scan(16'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", evals, fails);
    $finish;
  end
endmodule

// File: doc/keypad_scan.md
# keypad_scan

Scans a 4x4 matrix keypad by driving one column low at a time and sampling the active-low rows. It debounces each full-scan result and produces a 4-bit hex key code with a one-cycle new-key strobe. It sits directly upstream of the 7-segment decoder: `key_val` drives the decoder's 4-bit display value input.

## Interface
- `SCAN_CYCLES`, default 100000: clock cycles each column is driven (1 ms at 100 MHz); legal range ≥ 4.
- `DEBOUNCE_SCANS`, default 4: consecutive identical full-scan results required to accept a press or release; legal range ≥ 1.
- `clk` in 1: system clock; the only clock in the block.
- `reset` in 1: synchronous, active-high reset.
- `row` in 4: keypad rows, active-low, externally pulled up, asynchronous to `clk`.
- `col` out 4: keypad column drive, active-low, exactly one bit low at all times.
- `key_val` out 4: hex code of the last accepted key; held until the next accepted press.
- `key_valid` out 1: one-cycle pulse when a new press is accepted.
- `key_down` out 1: level, high while an accepted key is held.

## Operation
- **Row synchronizer:** `row` passes through a 2-flop synchronizer; all sampling uses the synchronized value.
- **Column sequencer:**
  - Column index cycles 0→1→2→3→0; `col = ~(4'b0001 << idx)`.
  - A cycle counter runs 0..SCAN_CYCLES-1 per column.
  - Rows are sampled on count SCAN_CYCLES-1, which is also the cycle the index advances.
- **Key map** (col,row → code):
  - row0: (0,0)=1, (1,0)=2, (2,0)=3, (3,0)=A
  - row1: (0,1)=4, (1,1)=5, (2,1)=6, (3,1)=B
  - row2: (0,2)=7, (1,2)=8, (2,2)=9, (3,2)=C
  - row3: (0,3)=0, (1,3)=F, (2,3)=E, (3,3)=D
- **Scan result:** accumulated over the four column samples of one scan.
  - NONE: no low row in any column.
  - KEY(code): exactly one low row across the whole scan.
  - MULTI: two or more low rows.
- **Debounce:**
  - At the end of each scan (column-3 sample), compare the result with the previous scan's result (class and code).
  - Equal: increment the stable count, saturating at DEBOUNCE_SCANS.
  - Different: load the stable count with 1 and store the new result.
- **Acceptance:** evaluated in the cycle after a scan end where the stable count equals DEBOUNCE_SCANS.
  - KEY with `key_down`=0: load `key_val` with the code, pulse `key_valid`, set `key_down`=1.
  - KEY with `key_down`=1: no change. A held key never re-strobes, even if it changes to a different stable key without a NONE in between.
  - NONE: clear `key_down`; `key_val` is held.
  - MULTI: no change to any output.
- **Reset:** applies in any state, including mid-column.
  - Column index 0, `col`=4'b1110, cycle counter 0.
  - Synchronizer flops set to 4'b1111, previous result NONE, stable count 0.
  - `key_val`=0, `key_valid`=0, `key_down`=0.

## Timing
- All outputs are registered; none depends combinationally on `row`.
- `col` changes only in the cycle after a sample. Each column is low for exactly SCAN_CYCLES cycles, and one full scan takes 4×SCAN_CYCLES cycles.
- Synchronizer latency is 2 cycles. SCAN_CYCLES ≥ 4 guarantees the sampled rows reflect the current column.
- Press latency: `key_valid` rises 1 cycle after the column-3 sample ending the DEBOUNCE_SCANS-th consecutive identical KEY scan. Worst case from a stable press is (DEBOUNCE_SCANS+1)×4×SCAN_CYCLES + 3 cycles.
- `key_valid` is high for exactly 1 cycle per accepted press.
- Release latency follows the same rule, using NONE scans.
- The first acceptance after reset needs DEBOUNCE_SCANS complete scans.

## Test plan
All scenarios use SCAN_CYCLES=8 and DEBOUNCE_SCANS=3, with a keypad model that pulls a row low while its column is low.

- **Reset:** assert `reset` mid-column 2 → next cycle `col`=1110, `key_val`=0, `key_valid`=0, `key_down`=0. `col` steps 1101, 1011, 0111 at 8-cycle intervals.
- **Single press:** hold key (1,1) → exactly one `key_valid` pulse with `key_val`=5 and `key_down`=1, 1 cycle after the third full scan end. No further pulse during 20 more scans of hold.
- **Release:** release key 5 → `key_down` falls 1 cycle after the third NONE scan end; `key_val` stays 5. Then press (3,3) → `key_val`=D with one pulse.
- **Bounce:** alternate key (2,0) present/absent on successive scans for 10 scans → no `key_valid` pulse, `key_down`=0. Then hold steady → `key_val`=3 after 3 scans.
- **Multi-key:** hold (0,0) and (2,2) together → no pulse and outputs unchanged. Release (2,2) → `key_val`=1 after 3 scans.
- **Reset mid-debounce:** press key (1,3), assert reset after 2 scans → no pulse. Count restarts; `key_val`=F only after 3 full scans after reset.
